// File: rtl/hack_core_if.sv
// Fetch and data-memory handshake bundle for hack_core.
interface hack_core_if #(
    parameter int DATA_W = 16
);
    logic              instr_req;
    logic              instr_ready;
    logic [15:0]       instruction;
    logic              mem_req;
    logic              mem_write;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output instr_req,
        input  instr_ready,
        input  instruction,
        output mem_req,
        output mem_write,
        input  mem_ready,
        output mem_address,
        input  mem_rdata,
        output mem_wdata
    );

    modport slave (
        input  instr_req,
        output instr_ready,
        output instruction,
        input  mem_req,
        input  mem_write,
        output mem_ready,
        input  mem_address,
        output mem_rdata,
        input  mem_wdata
    );
endinterface

// File: rtl/hack_core.sv
// Multi-cycle Hack CPU: FETCH -> DECODE -> (MEM_READ) -> WRITE_BACK.
// Memory-side outputs are decoded from the state and registers only, so they
// stay stable while a request waits for its ready.
module hack_core #(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    hack_core_if.master       bus,
    output logic [PC_W-1:0]   prog_counter,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg
);
    typedef enum logic [1:0] {FETCH, DECODE, MEM_READ, WRITE_BACK} state_t;

    state_t            state, state_nxt;
    logic [15:0]       ir;       // latched instruction (comp/dest/jump fields)
    logic [DATA_W-1:0] y_op;     // ALU y operand: A or M
    logic [DATA_W-1:0] x, y, res;
    logic              zero, neg, taken, commit;
    logic              instr_req, mem_req, mem_write;

    // Hack ALU: x is always D; control bits zx nx zy ny f no = ir[11:6]
    always_comb begin
        x = d_reg;
        y = y_op;
        if (ir[11]) x = '0;
        if (ir[10]) x = ~x;
        if (ir[9])  y = '0;
        if (ir[8])  y = ~y;
        res = ir[7] ? (x + y) : (x & y);
        if (ir[6])  res = ~res;
    end

    assign zero  = (res == '0);
    assign neg   = res[DATA_W-1];
    assign taken = (ir[2] & neg) | (ir[1] & zero) | (ir[0] & ~neg & ~zero);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    // Next-state and handshake decode; commit marks the cycle an instruction retires
    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        commit    = 1'b0;
        case (state)
            FETCH: begin
                instr_req = 1'b1;
                if (bus.instr_ready) state_nxt = DECODE;
            end
            DECODE: begin
                if (!ir[15])    state_nxt = FETCH;
                else if (ir[12]) state_nxt = MEM_READ;
                else            state_nxt = WRITE_BACK;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                if (bus.mem_ready) state_nxt = WRITE_BACK;
            end
            WRITE_BACK: begin
                if (ir[3]) begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        commit    = 1'b1;
                        state_nxt = FETCH;
                    end
                end else begin
                    commit    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Datapath registers; WRITE_BACK updates all use pre-update A and D
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_counter <= PC_W'(RESET_PC);
            a_reg        <= '0;
            d_reg        <= '0;
            ir           <= '0;
            y_op         <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.instr_ready) ir <= bus.instruction;
                end
                DECODE: begin
                    if (!ir[15]) begin
                        a_reg        <= {{(DATA_W-15){1'b0}}, ir[14:0]};
                        prog_counter <= prog_counter + PC_W'(1);
                    end else if (!ir[12]) begin
                        y_op <= a_reg;
                    end
                end
                MEM_READ: begin
                    if (bus.mem_ready) y_op <= bus.mem_rdata;
                end
                WRITE_BACK: begin
                    if (commit) begin
                        if (ir[5]) a_reg <= res;
                        if (ir[4]) d_reg <= res;
                        prog_counter <= taken ? a_reg[PC_W-1:0] : prog_counter + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_req   = instr_req;
    assign bus.mem_req     = mem_req;
    assign bus.mem_write   = mem_write;
    assign bus.mem_address = a_reg;
    assign bus.mem_wdata   = res;
endmodule
